// File: rtl/alu_result_unit_if.sv
// ============================================================================
//  Module   : alu_result_unit_if
//  Purpose  : Operation/result bus of the ALU result unit (issue side, result
//             side, HI/LO and divider status).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface alu_result_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       funct;
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] shift_out;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic [WIDTH-1:0] data_out;
  logic             illegal;
  logic             busy;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  modport master (
    output in_valid, funct, alu_out, shift_out, op_a, op_b,
    input  in_ready, out_valid, data_out, illegal, busy, hi_q, lo_q
  );

  modport slave (
    input  in_valid, funct, alu_out, shift_out, op_a, op_b,
    output in_ready, out_valid, data_out, illegal, busy, hi_q, lo_q
  );
endinterface

`default_nettype wire

// File: rtl/alu_result_unit.sv
// ============================================================================
//  Module   : alu_result_unit
//  Purpose  : Registered ALU result select with HI/LO pair and an iterative
//             restoring unsigned divider (DIVU / MFHI / MFLO).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_result_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  alu_result_unit_if.slave bus
);

  localparam logic [5:0] c_FN_AND  = 6'b100100;
  localparam logic [5:0] c_FN_OR   = 6'b100101;
  localparam logic [5:0] c_FN_ADD  = 6'b100000;
  localparam logic [5:0] c_FN_SUB  = 6'b100010;
  localparam logic [5:0] c_FN_SLT  = 6'b101010;
  localparam logic [5:0] c_FN_SRL  = 6'b000010;
  localparam logic [5:0] c_FN_MFHI = 6'b010000;
  localparam logic [5:0] c_FN_MFLO = 6'b010010;
  localparam logic [5:0] c_FN_DIVU = 6'b011011;

  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_DIV  = 1'b1;

  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic             r_out_valid;
  logic             r_illegal;

  logic             w_busy;
  logic             w_accept;
  logic             w_gpr;
  logic             w_div_op;
  logic [WIDTH-1:0] w_result;
  logic [WIDTH:0]   w_rem_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;

  assign w_busy   = (r_state == c_ST_DIV);
  assign w_accept = bus.in_valid && !w_busy;

  always_comb begin
    w_gpr    = 1'b0;
    w_div_op = 1'b0;
    w_result = r_data;
    case (bus.funct)
      c_FN_AND, c_FN_OR, c_FN_ADD, c_FN_SUB, c_FN_SLT: begin
        w_gpr    = 1'b1;
        w_result = bus.alu_out;
      end
      c_FN_SRL: begin
        w_gpr    = 1'b1;
        w_result = bus.shift_out;
      end
      c_FN_MFHI: begin
        w_gpr    = 1'b1;
        w_result = r_hi;
      end
      c_FN_MFLO: begin
        w_gpr    = 1'b1;
        w_result = r_lo;
      end
      c_FN_DIVU: w_div_op = 1'b1;
      default: ;
    endcase
  end

  // Restoring step: the dividend is shifted out of r_quo MSB-first while the
  // quotient bits are shifted in at the bottom. The compare is WIDTH+1 wide;
  // when it succeeds the true difference is below the divisor, so the low
  // WIDTH bits of the subtraction are exact.
  assign w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_div});
  assign w_diff    = w_rem_sh[WIDTH-1:0] - r_div;
  assign w_rem_nxt = w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= c_ST_IDLE;
      r_cnt       <= '0;
      r_data      <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_div       <= '0;
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_out_valid <= w_accept && w_gpr;
      r_illegal   <= w_accept && !w_gpr && !w_div_op;
      if (w_accept && w_gpr) begin
        r_data <= w_result;
      end
      case (r_state)
        c_ST_IDLE: begin
          if (w_accept && w_div_op) begin
            r_state <= c_ST_DIV;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= bus.op_a;
            r_div   <= bus.op_b;
          end
        end
        c_ST_DIV: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + c_CNT_ONE;
          // HI/LO only ever see the finished result
          if (r_cnt == c_CNT_LAST) begin
            r_hi    <= w_rem_nxt;
            r_lo    <= w_quo_nxt;
            r_state <= c_ST_IDLE;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = !w_busy;
  assign bus.busy      = w_busy;
  assign bus.out_valid = r_out_valid;
  assign bus.illegal   = r_illegal;
  assign bus.data_out  = r_data;
  assign bus.hi_q      = r_hi;
  assign bus.lo_q      = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_alu_result_unit.sv
// ============================================================================
//  Module   : tb_alu_result_unit
//  Purpose  : Self-checking bench for alu_result_unit at WIDTH=32 and WIDTH=8.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_result_unit;

  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MFLO = 6'b010010;
  localparam logic [5:0] F_DIVU = 6'b011011;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_mis;

  alu_result_unit_if #(.WIDTH(32)) b32 ();
  alu_result_unit_if #(.WIDTH(8))  b8 ();

  alu_result_unit #(.WIDTH(32), .CNT_W(6)) u_dut32 (.clk(clk), .rst(rst), .bus(b32));
  alu_result_unit #(.WIDTH(8),  .CNT_W(4)) u_dut8  (.clk(clk), .rst(rst), .bus(b8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: index 0 = 32-bit instance, 1 = 8-bit instance
  int          m_w[2] = '{32, 8};
  logic [31:0] m_data[2];
  logic [31:0] m_hi[2];
  logic [31:0] m_lo[2];
  logic [31:0] m_a[2];
  logic [31:0] m_b[2];
  bit          m_ov[2];
  bit          m_ill[2];
  int          m_left[2];

  task automatic model_reset(input int k);
    m_data[k] = 0; m_hi[k] = 0; m_lo[k] = 0; m_a[k] = 0; m_b[k] = 0;
    m_ov[k] = 0; m_ill[k] = 0; m_left[k] = 0;
  endtask

  task automatic model_edge(input int k, input bit v, input logic [5:0] f,
                            input logic [31:0] alu, input logic [31:0] sh,
                            input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mask;
    bit acc;
    mask = 32'hFFFF_FFFF >> (32 - m_w[k]);
    acc  = v && (m_left[k] == 0);
    m_ov[k]  = 0;
    m_ill[k] = 0;
    if (m_left[k] > 0) begin
      m_left[k]--;
      if (m_left[k] == 0) begin
        if (m_b[k] == 0) begin
          m_lo[k] = mask;
          m_hi[k] = m_a[k];
        end else begin
          m_lo[k] = m_a[k] / m_b[k];
          m_hi[k] = m_a[k] % m_b[k];
        end
      end
    end
    if (acc) begin
      case (f)
        F_AND, F_OR, F_ADD, F_SUB, F_SLT: begin m_data[k] = alu & mask; m_ov[k] = 1; end
        F_SRL:  begin m_data[k] = sh & mask; m_ov[k] = 1; end
        F_MFHI: begin m_data[k] = m_hi[k];   m_ov[k] = 1; end
        F_MFLO: begin m_data[k] = m_lo[k];   m_ov[k] = 1; end
        F_DIVU: begin m_a[k] = a & mask; m_b[k] = b & mask; m_left[k] = m_w[k]; end
        default: m_ill[k] = 1;
      endcase
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_edge(0, b32.in_valid, b32.funct, b32.alu_out, b32.shift_out, b32.op_a, b32.op_b);
      model_edge(1, b8.in_valid, b8.funct, {24'b0, b8.alu_out}, {24'b0, b8.shift_out},
                 {24'b0, b8.op_a}, {24'b0, b8.op_b});
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  bit run_cmp;

  always @(negedge clk) begin
    if (run_cmp && !rst) begin
      chk("data32",  b32.data_out,            m_data[0]);
      chk("ov32",    {31'b0, b32.out_valid},  {31'b0, m_ov[0]});
      chk("ill32",   {31'b0, b32.illegal},    {31'b0, m_ill[0]});
      chk("busy32",  {31'b0, b32.busy},       {31'b0, m_left[0] > 0});
      chk("ready32", {31'b0, b32.in_ready},   {31'b0, m_left[0] == 0});
      chk("hi32",    b32.hi_q,                m_hi[0]);
      chk("lo32",    b32.lo_q,                m_lo[0]);
      chk("data8",   {24'b0, b8.data_out},    m_data[1]);
      chk("ov8",     {31'b0, b8.out_valid},   {31'b0, m_ov[1]});
      chk("ill8",    {31'b0, b8.illegal},     {31'b0, m_ill[1]});
      chk("busy8",   {31'b0, b8.busy},        {31'b0, m_left[1] > 0});
      chk("hi8",     {24'b0, b8.hi_q},        m_hi[1]);
      chk("lo8",     {24'b0, b8.lo_q},        m_lo[1]);
    end
  end

  task automatic set32(input bit v, input logic [5:0] f, input logic [31:0] alu,
                       input logic [31:0] sh, input logic [31:0] a, input logic [31:0] b);
    b32.in_valid = v; b32.funct = f; b32.alu_out = alu;
    b32.shift_out = sh; b32.op_a = a; b32.op_b = b;
  endtask

  task automatic idle32();
    b32.in_valid = 1'b0;
  endtask

  // Issue a 32-bit DIVU, wait it out and check the literal results.
  task automatic div32(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int n;
    @(negedge clk);
    set32(1'b1, F_DIVU, 32'h0, 32'h0, a, b);
    @(negedge clk);
    idle32();
    n = 0;
    while (b32.busy && n < 100) begin
      chk("div_ready_low", {31'b0, b32.in_ready}, 32'd0);
      n++;
      @(negedge clk);
    end
    chk("div_busy_cycles", n, 32);
    chk("div_lo", b32.lo_q, exp_lo);
    chk("div_hi", b32.hi_q, exp_hi);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1);
  end

  initial begin
    int n;
    n_vec = 0; n_mis = 0; run_cmp = 1'b0;
    rst = 1'b1;
    set32(1'b0, 6'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    b8.in_valid = 1'b0; b8.funct = 6'h0; b8.alu_out = 8'h0;
    b8.shift_out = 8'h0; b8.op_a = 8'h0; b8.op_b = 8'h0;
    #12;
    chk("rst_data",  b32.data_out, 32'h0);
    chk("rst_busy",  {31'b0, b32.busy}, 32'd0);
    chk("rst_ready", {31'b0, b32.in_ready}, 32'd1);
    chk("rst_ov",    {31'b0, b32.out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_cmp = 1'b1;

    // ADD then hold
    set32(1'b1, F_ADD, 32'h7, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("add_data", b32.data_out, 32'h7);
    chk("add_ov",   {31'b0, b32.out_valid}, 32'd1);
    idle32();
    @(negedge clk);
    chk("add_hold_ov",   {31'b0, b32.out_valid}, 32'd0);
    chk("add_hold_data", b32.data_out, 32'h7);

    // SRL picks the shifter, then back-to-back AND / OR
    set32(1'b1, F_SRL, 32'h1234, 32'h8000_0000, 32'h0, 32'h0);
    @(negedge clk);
    chk("srl_data", b32.data_out, 32'h8000_0000);
    set32(1'b1, F_AND, 32'h0000_00F0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("and_data", b32.data_out, 32'h0000_00F0);
    chk("and_ov",   {31'b0, b32.out_valid}, 32'd1);
    set32(1'b1, F_OR, 32'hA5A5_0000, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("or_data", b32.data_out, 32'hA5A5_0000);
    chk("or_ov",   {31'b0, b32.out_valid}, 32'd1);
    set32(1'b1, F_SUB, 32'hFFFF_FFFE, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    set32(1'b1, F_SLT, 32'h1, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("slt_data", b32.data_out, 32'h1);
    idle32();

    // DIVU 100/7 with in_valid offered (and ignored) while busy
    @(negedge clk);
    set32(1'b1, F_DIVU, 32'h0, 32'h0, 32'd100, 32'd7);
    @(negedge clk);
    set32(1'b1, F_ADD, 32'hDEAD_BEEF, 32'h0, 32'd55, 32'd0);
    n = 0;
    while (b32.busy && n < 100) begin
      chk("divu_ready_low", {31'b0, b32.in_ready}, 32'd0);
      chk("divu_no_ov",     {31'b0, b32.out_valid}, 32'd0);
      n++;
      @(negedge clk);
    end
    idle32();
    chk("divu_busy_cycles", n, 32);
    chk("divu_hi", b32.hi_q, 32'd2);
    chk("divu_lo", b32.lo_q, 32'd14);
    chk("divu_data_kept", b32.data_out, 32'h1);
    set32(1'b1, F_MFLO, 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("mflo_data", b32.data_out, 32'd14);
    set32(1'b1, F_MFHI, 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("mfhi_data", b32.data_out, 32'd2);
    idle32();

    // divide by zero and divisor larger than dividend
    div32(32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    div32(32'd5, 32'd9, 32'd0, 32'd5);
    div32(32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 32'h0);

    // asynchronous reset in the middle of a divide
    @(negedge clk);
    set32(1'b1, F_DIVU, 32'h0, 32'h0, 32'd1000, 32'd3);
    @(negedge clk);
    idle32();
    repeat (9) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy",  {31'b0, b32.busy}, 32'd0);
    chk("arst_ready", {31'b0, b32.in_ready}, 32'd1);
    chk("arst_hi",    b32.hi_q, 32'd0);
    chk("arst_lo",    b32.lo_q, 32'd0);
    chk("arst_data",  b32.data_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    div32(32'd9, 32'd3, 32'd3, 32'd0);

    // unrecognised funct leaves data_out alone
    @(negedge clk);
    set32(1'b1, F_ADD, 32'h55, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    set32(1'b1, 6'b111111, 32'h99, 32'h77, 32'h0, 32'h0);
    @(negedge clk);
    chk("ill_pulse", {31'b0, b32.illegal}, 32'd1);
    chk("ill_no_ov", {31'b0, b32.out_valid}, 32'd0);
    chk("ill_data",  b32.data_out, 32'h55);
    idle32();
    @(negedge clk);
    chk("ill_clear", {31'b0, b32.illegal}, 32'd0);

    // 8-bit instance: DIVU 200/16
    b8.in_valid = 1'b1; b8.funct = F_DIVU; b8.op_a = 8'd200; b8.op_b = 8'd16;
    @(negedge clk);
    b8.in_valid = 1'b0;
    n = 0;
    while (b8.busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("w8_busy_cycles", n, 8);
    chk("w8_lo", {24'b0, b8.lo_q}, 32'd12);
    chk("w8_hi", {24'b0, b8.hi_q}, 32'd8);
    b8.in_valid = 1'b1; b8.funct = F_MFHI;
    @(negedge clk);
    b8.in_valid = 1'b0;
    chk("w8_mfhi", {24'b0, b8.data_out}, 32'd8);

    repeat (3) @(negedge clk);
    run_cmp = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
